// File: rtl/rc5_key_expand_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rc5_key_expand_if                                             |
// | Brief    : Key byte stream and S-table read bus of rc5_key_expand        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface rc5_key_expand_if #(
  parameter int W        = 32,
  parameter int T_LENGTH = 5
);
  logic [7:0]          iKey_byte;
  logic                iKey_valid;
  logic                oKey_ready;
  logic [T_LENGTH-1:0] iS_address1;
  logic [T_LENGTH-1:0] iS_address2;
  logic [W-1:0]        oS_sub_i1;
  logic [W-1:0]        oS_sub_i2;

  modport master (
    output iKey_byte, iKey_valid, iS_address1, iS_address2,
    input  oKey_ready, oS_sub_i1, oS_sub_i2
  );

  modport slave (
    input  iKey_byte, iKey_valid, iS_address1, iS_address2,
    output oKey_ready, oS_sub_i1, oS_sub_i2
  );
endinterface
`default_nettype wire

// File: rtl/rc5_key_expand.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rc5_key_expand                                                |
// | Brief    : RC5 key schedule; builds S[0..T-1] and serves it on two       |
// |            registered read ports. RC5_KEY_ZEROIZE_EN adds a WIPE state.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rc5_key_expand #(
  parameter int W = 32,
  parameter int R = 12,
  parameter int B = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iStart,
  output logic            oDone,
  rc5_key_expand_if.slave bus
);

  localparam int T        = 2 * (R + 1);
  localparam int T_LENGTH = $clog2(T);
  localparam int C        = (8 * B + W - 1) / W;
  localparam int C_LENGTH = (C > 1) ? $clog2(C) : 1;
  localparam int MAXTC    = (T > C) ? T : C;
  localparam int N_ITER   = 3 * MAXTC;
  localparam int NW       = $clog2(N_ITER + 1);
  localparam int KW       = (B > 1) ? $clog2(B) : 1;
  localparam int LOGW     = $clog2(W);
  localparam int LOGBYTES = $clog2(W / 8);

  localparam logic [63:0] c_p64 = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                  (W == 32) ? 64'h0000_0000_B7E1_5163 :
                                              64'hB7E1_5162_8AED_2A6B;
  localparam logic [63:0] c_q64 = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                  (W == 32) ? 64'h0000_0000_9E37_79B9 :
                                              64'h9E37_79B9_7F4A_7C15;

  localparam logic [W-1:0]        c_p      = c_p64[W-1:0];
  localparam logic [W-1:0]        c_q      = c_q64[W-1:0];
  localparam logic [T_LENGTH-1:0] c_tLast  = T_LENGTH'(T - 1);
  localparam logic [T_LENGTH:0]   c_tCount = (T_LENGTH + 1)'(T);
  localparam logic [C_LENGTH-1:0] c_cLast  = C_LENGTH'(C - 1);
  localparam logic [NW-1:0]       c_nIter  = NW'(N_ITER);
  localparam logic [KW-1:0]       c_kFirst = KW'(B - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_S   = 3'd1,
    LOAD_KEY = 3'd2,
    MIX_A    = 3'd3,
    MIX_B    = 3'd4,
`ifdef RC5_KEY_ZEROIZE_EN
    WIPE     = 3'd6,
`endif
    DONE     = 3'd5
  } state_t;

`ifdef RC5_KEY_ZEROIZE_EN
  localparam state_t c_abortState = WIPE;
`else
  localparam state_t c_abortState = IDLE;
`endif

  state_t              r_state;
  logic [W-1:0]        r_s [T];
  logic [W-1:0]        r_l [C];
  logic [T_LENGTH-1:0] r_i;
  logic [C_LENGTH-1:0] r_j;
  logic [NW-1:0]       r_n;
  logic [KW-1:0]       r_k;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic                r_done;
  logic                r_keyReady;
  logic [W-1:0]        r_sub1;
  logic [W-1:0]        r_sub2;

  logic [W-1:0]        w_initVal;
  logic [W-1:0]        w_newA;
  logic [W-1:0]        w_newB;
  logic [LOGW-1:0]     w_rotB;
  logic [C_LENGTH-1:0] w_lIdx;
  logic                w_accept;
  logic                w_abort;
  logic [W-1:0]        w_rd1;
  logic [W-1:0]        w_rd2;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LOGW-1:0] s);
    return W'(({x, x} << s) >> W);
  endfunction

  assign w_initVal = (r_i == '0) ? c_p : r_a + c_q;
  assign w_newA    = rotl(r_s[r_i] + r_a + r_b, LOGW'(3));
  assign w_rotB    = LOGW'(r_a + r_b);
  assign w_newB    = rotl(r_l[r_j] + r_a + r_b, w_rotB);
  // Key bytes arrive highest index first; each one shifts into word k/(W/8).
  assign w_lIdx    = C_LENGTH'(r_k >> LOGBYTES);
  assign w_accept  = r_keyReady && bus.iKey_valid;
  assign w_rd1     = ({1'b0, bus.iS_address1} < c_tCount) ? r_s[bus.iS_address1] : '0;
  assign w_rd2     = ({1'b0, bus.iS_address2} < c_tCount) ? r_s[bus.iS_address2] : '0;

`ifdef RC5_KEY_ZEROIZE_EN
  assign w_abort = !iStart && (r_state != IDLE) && (r_state != WIPE);
`else
  assign w_abort = !iStart && (r_state != IDLE);
`endif

  assign oDone          = r_done;
  assign bus.oKey_ready = r_keyReady;
  assign bus.oS_sub_i1  = r_sub1;
  assign bus.oS_sub_i2  = r_sub2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_done     <= 1'b0;
      r_keyReady <= 1'b0;
      r_i        <= '0;
      r_j        <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sub1     <= '0;
      r_sub2     <= '0;
    end else begin
      // Reads are only live while the table is complete and being kept.
      r_sub1 <= (r_state == DONE && iStart) ? w_rd1 : '0;
      r_sub2 <= (r_state == DONE && iStart) ? w_rd2 : '0;
      if (w_abort) begin
        r_state    <= c_abortState;
        r_done     <= 1'b0;
        r_keyReady <= 1'b0;
        r_i        <= '0;
        r_j        <= '0;
        r_n        <= '0;
        r_k        <= '0;
        r_a        <= '0;
        r_b        <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (iStart) begin
              r_state <= INIT_S;
              r_i     <= '0;
            end
          end
          INIT_S: begin
            r_a <= w_initVal;
            if (r_i == c_tLast) begin
              r_i        <= '0;
              r_k        <= c_kFirst;
              r_keyReady <= 1'b1;
              r_state    <= LOAD_KEY;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end
          LOAD_KEY: begin
            if (w_accept) begin
              if (r_k == '0) begin
                r_keyReady <= 1'b0;
                r_a        <= '0;
                r_b        <= '0;
                r_i        <= '0;
                r_j        <= '0;
                r_n        <= c_nIter;
                r_state    <= MIX_A;
              end else begin
                r_k <= r_k - 1'b1;
              end
            end
          end
          MIX_A: begin
            r_a     <= w_newA;
            r_state <= MIX_B;
          end
          MIX_B: begin
            r_b <= w_newB;
            r_i <= (r_i == c_tLast) ? '0 : r_i + 1'b1;
            r_j <= (r_j == c_cLast) ? '0 : r_j + 1'b1;
            r_n <= r_n - 1'b1;
            if (r_n == NW'(1)) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= MIX_A;
            end
          end
          DONE: r_state <= DONE;
`ifdef RC5_KEY_ZEROIZE_EN
          WIPE: begin
            if (r_n == NW'(MAXTC - 1)) begin
              r_n     <= '0;
              r_state <= IDLE;
            end else begin
              r_n <= r_n + 1'b1;
            end
          end
`endif
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Table storage carries no reset; contents only matter once rebuilt.
  always_ff @(posedge clk) begin
    case (r_state)
      INIT_S: begin
        r_s[r_i] <= w_initVal;
        if (r_i == '0) begin
          for (int c = 0; c < C; c++) r_l[c] <= '0;
        end
      end
      LOAD_KEY: if (w_accept) r_l[w_lIdx] <= {r_l[w_lIdx][W-9:0], bus.iKey_byte};
      MIX_A:    r_s[r_i] <= w_newA;
      MIX_B:    r_l[r_j] <= w_newB;
`ifdef RC5_KEY_ZEROIZE_EN
      WIPE: begin
        if (r_n < NW'(T)) r_s[T_LENGTH'(r_n)] <= '0;
        if (r_n < NW'(C)) r_l[C_LENGTH'(r_n)] <= '0;
      end
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rc5_key_expand.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rc5_key_expand                                             |
// | Brief    : Directed bench for rc5_key_expand using RC5-32/12/16 vectors  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_rc5_key_expand;

  logic clk = 1'b0;
  logic rst;
  logic iStart;
  logic oDone;

  always #5 clk = ~clk;

  rc5_key_expand_if #(.W(32), .T_LENGTH(5)) bus ();

  rc5_key_expand #(.W(32), .R(12), .B(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .iStart (iStart),
    .oDone  (oDone),
    .bus    (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  keyZero [16];
  logic [7:0]  keyV2   [16];
  logic [31:0] sTab    [26];

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] d;
    d = {x, x} >> s;
    return d[31:0];
  endfunction

  function automatic logic [63:0] decipher(input logic [31:0] ca, input logic [31:0] cb);
    logic [31:0] a;
    logic [31:0] b;
    a = ca;
    b = cb;
    for (int i = 12; i >= 1; i--) begin
      b = rotr(b - sTab[2*i+1], a[4:0]) ^ a;
      a = rotr(a - sTab[2*i], b[4:0]) ^ b;
    end
    b = b - sTab[1];
    a = a - sTab[0];
    return {a, b};
  endfunction

  task automatic idle(input int n);
    iStart         = 1'b0;
    bus.iKey_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise iStart and stream the key (K[15] first); optional gap after the first byte.
  task automatic run_key(input logic [7:0] key [16], input int nStall, input int maxCyc,
                         output int lat, output int nzBefore,
                         output logic [31:0] s1Done, output logic [31:0] s2Done);
    int   n;
    int   stallLeft;
    logic acc;
    n = 0; stallLeft = nStall; lat = -1; nzBefore = 0;
    s1Done = '1; s2Done = '1;
    iStart = 1'b1; bus.iKey_valid = 1'b1; bus.iKey_byte = key[15];
    for (int cyc = 1; cyc <= maxCyc; cyc++) begin
      acc = bus.oKey_ready && bus.iKey_valid;
      @(posedge clk); #1;
      if (acc) n++;
      if (n >= 16) bus.iKey_valid = 1'b0;
      else if (n >= 1 && stallLeft > 0) begin
        bus.iKey_valid = 1'b0;
        stallLeft--;
      end else begin
        bus.iKey_valid = 1'b1;
        bus.iKey_byte  = key[15-n];
      end
      if (oDone) begin
        lat = cyc; s1Done = bus.oS_sub_i1; s2Done = bus.oS_sub_i2;
        break;
      end
      if (bus.oS_sub_i1 != 0 || bus.oS_sub_i2 != 0) nzBefore++;
    end
  endtask

  task automatic read_table();
    for (int k = 0; k < 13; k++) begin
      bus.iS_address1 = 5'(2*k);
      bus.iS_address2 = 5'(2*k+1);
      @(posedge clk); #1;
      sTab[2*k]   = bus.oS_sub_i1;
      sTab[2*k+1] = bus.oS_sub_i2;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (oDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", oDone); end
    total++; if (bus.oKey_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.oKey_ready); end
    total++; if (bus.oS_sub_i1 !== 32'h0) begin bad++; $display("FAIL reset_sub1: got %h want 0", bus.oS_sub_i1); end
    total++; if (bus.oS_sub_i2 !== 32'h0) begin bad++; $display("FAIL reset_sub2: got %h want 0", bus.oS_sub_i2); end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_zero_key();
    int lat, nz; logic [31:0] s1, s2; logic [63:0] pt;
    bus.iS_address1 = 5'd5; bus.iS_address2 = 5'd0;
    run_key(keyZero, 0, 400, lat, nz, s1, s2);
    total++; if (lat != 199) begin bad++; $display("FAIL zero_latency: got %0d want 199", lat); end
    total++; if (nz != 0) begin bad++; $display("FAIL zero_gate_before_done: got %0d nonzero reads want 0", nz); end
    total++; if (s1 !== 32'h0) begin bad++; $display("FAIL zero_gate_done_entry1: got %h want 0", s1); end
    total++; if (s2 !== 32'h0) begin bad++; $display("FAIL zero_gate_done_entry2: got %h want 0", s2); end
    read_table();
    pt = decipher(32'hEEDBA521, 32'h6D8F4B15);
    total++; if (pt[63:32] !== 32'h0) begin bad++; $display("FAIL zero_decipher_a: got %h want 00000000", pt[63:32]); end
    total++; if (pt[31:0] !== 32'h0) begin bad++; $display("FAIL zero_decipher_b: got %h want 00000000", pt[31:0]); end
  endtask

  task automatic test_read_ports();
    bus.iS_address1 = 5'd5; bus.iS_address2 = 5'd5;
    @(posedge clk); #1;
    total++; if (bus.oS_sub_i1 !== bus.oS_sub_i2) begin bad++; $display("FAIL same_addr: port1 %h port2 %h", bus.oS_sub_i1, bus.oS_sub_i2); end
    total++; if (bus.oS_sub_i1 !== sTab[5]) begin bad++; $display("FAIL addr5_port1: got %h want %h", bus.oS_sub_i1, sTab[5]); end
  endtask

  task automatic test_drop_done();
    iStart = 1'b0;
    @(posedge clk); #1;
    total++; if (oDone !== 1'b0) begin bad++; $display("FAIL drop_done: got %b want 0", oDone); end
    total++; if (bus.oS_sub_i1 !== 32'h0) begin bad++; $display("FAIL drop_gate: got %h want 0", bus.oS_sub_i1); end
    idle(30);
  endtask

  task automatic check_v2(input int lat, input int wantLat, input string tag);
    logic [63:0] pt;
    read_table();
    pt = decipher(32'hAC13C0F7, 32'h52892B5B);
    total++; if (lat != wantLat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", tag, lat, wantLat); end
    total++; if (pt[63:32] !== 32'hEEDBA521) begin bad++; $display("FAIL %s_decipher_a: got %h want eedba521", tag, pt[63:32]); end
    total++; if (pt[31:0] !== 32'h6D8F4B15) begin bad++; $display("FAIL %s_decipher_b: got %h want 6d8f4b15", tag, pt[31:0]); end
  endtask

  task automatic test_vector2();
    int lat, nz; logic [31:0] s1, s2;
    run_key(keyV2, 0, 400, lat, nz, s1, s2);
    check_v2(lat, 199, "v2");
    idle(30);
  endtask

  task automatic test_stall();
    int lat, nz; logic [31:0] s1, s2;
    run_key(keyV2, 2, 400, lat, nz, s1, s2);
    check_v2(lat, 201, "stall");
    idle(30);
  endtask

  task automatic test_abort_mix();
    int lat, nz; logic [31:0] s1, s2;
    run_key(keyV2, 0, 80, lat, nz, s1, s2);
    iStart = 1'b0;
    @(posedge clk); #1;
    total++; if (oDone !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", oDone); end
    total++; if (bus.oKey_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", bus.oKey_ready); end
    idle(30);
    run_key(keyV2, 0, 400, lat, nz, s1, s2);
    check_v2(lat, 199, "rerun");
    idle(30);
  endtask

  task automatic test_async_reset();
    int lat, nz; logic [31:0] s1, s2;
    run_key(keyV2, 0, 30, lat, nz, s1, s2);
    total++; if (bus.oKey_ready !== 1'b1) begin bad++; $display("FAIL load_ready: got %b want 1", bus.oKey_ready); end
    #3 rst = 1'b0;
    #1;
    total++; if (bus.oKey_ready !== 1'b0) begin bad++; $display("FAIL areset_ready: got %b want 0", bus.oKey_ready); end
    total++; if (oDone !== 1'b0) begin bad++; $display("FAIL areset_done: got %b want 0", oDone); end
    iStart = 1'b0; bus.iKey_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    idle(3);
    run_key(keyV2, 0, 400, lat, nz, s1, s2);
    check_v2(lat, 199, "after_reset");
    idle(30);
  endtask

`ifdef RC5_KEY_ZEROIZE_EN
  task automatic test_zeroize();
    int lat, nz, nonZero; logic [31:0] s1, s2;
    run_key(keyV2, 0, 400, lat, nz, s1, s2);
    iStart = 1'b0;
    repeat (27) @(posedge clk);
    #1;
    nonZero = 0;
    for (int k = 0; k < 26; k++) if (dut.r_s[k] !== 32'h0) nonZero++;
    total++; if (nonZero != 0) begin bad++; $display("FAIL wipe_table: got %0d nonzero words want 0", nonZero); end
    idle(5);
  endtask
`endif

  initial begin
    rst = 1'b0; iStart = 1'b0;
    bus.iKey_valid = 1'b0; bus.iKey_byte = 8'h00;
    bus.iS_address1 = 5'd0; bus.iS_address2 = 5'd0;
    keyZero = '{default: 8'h00};
    keyV2   = '{8'h91, 8'h5F, 8'h46, 8'h19, 8'hBE, 8'h41, 8'hB2, 8'h51,
                8'h63, 8'h55, 8'hA5, 8'h01, 8'h10, 8'hA9, 8'hCE, 8'h91};
    test_reset();
    test_zero_key();
    test_read_ports();
    test_drop_done();
    test_vector2();
    test_stall();
    test_abort_mix();
    test_async_reset();
`ifdef RC5_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc5_key_expand.md
Name: rc5_key_expand

Overview:
RC5 key-schedule stage that sits directly upstream of the decipher block. It accepts a B-byte secret key byte-serially and builds the expanded key table S[0..T-1] with the standard P/Q initialisation and 3*max(T,C) mixing passes. It then serves S to the decipher through two registered read ports whose address/data naming matches the decipher's S interface.

Parameters:
W, 32, word width in bits; legal values 16/32/64.
R, 12, number of rounds. T = 2*(R+1) table words; T_LENGTH = $clog2(T).
B, 16, key length in bytes; legal range 1..255. C = ceil(8*B/W) key words; C_LENGTH = max(1,$clog2(C)).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
iStart  input  1  level: hold high to run/keep table; low aborts and returns to IDLE
iKey_byte  input  8  key byte
iKey_valid  input  1  iKey_byte valid
oKey_ready  output  1  high only in LOAD_KEY; a byte is accepted when iKey_valid && oKey_ready
iS_address1  input  T_LENGTH  read address port 1 (even index from decipher)
iS_address2  input  T_LENGTH  read address port 2 (odd index)
oS_sub_i1  output  W  S[iS_address1], registered
oS_sub_i2  output  W  S[iS_address2], registered
oDone  output  1  table complete and readable

Behaviour:
- Reset (rst low, async): state=IDLE; oDone=0; oKey_ready=0; oS_sub_i1=oS_sub_i2=0; i, j, A, B, counters=0. S/L array contents are undefined.
- Constants: P/Q = 0xB7E1/0x9E37 (W=16); 0xB7E15163/0x9E3779B9 (W=32); 0xB7E151628AED2A6B/0x9E3779B97F4A7C15 (W=64).
- All additions are mod 2^W. Rotate-left amount is the low log2(W) bits of the operand.
- States:
  - IDLE: waits for iStart=1, then goes to INIT_S.
  - INIT_S: T cycles, one word per cycle. S[0]=P, S[k]=S[k-1]+Q. Also clears L[0..C-1]=0. Then LOAD_KEY.
  - LOAD_KEY: oKey_ready=1. Key bytes arrive K[B-1] first, down to K[0]. Each accepted byte n (index k=B-1-n) performs L[k/(W/8)] = (L[k/(W/8)]<<8) + K[k]. Stalls indefinitely while iKey_valid=0. After B accepts, goes to MIX_A with A=B=i=j=0 and iteration count N=3*max(T,C).
  - MIX_A (1 cycle): A = S[i] = (S[i]+A+B) <<< 3.
  - MIX_B (1 cycle): B = L[j] = (L[j]+A+B) <<< (A+B), using the A written in MIX_A. Then i=(i+1) wraps at T-1→0, j=(j+1) wraps at C-1→0, N decrements. Goes to MIX_A, or to DONE when N reaches 0.
  - DONE: oDone=1. Table is frozen; stays in DONE while iStart=1.
- Any state, iStart=0: next cycle state=IDLE, oDone=0, oKey_ready=0. A partial key is discarded; a restart re-runs INIT_S.
- Read ports: 1-cycle latency; address at edge n gives data after edge n. Output is 0 whenever oDone=0 (including the cycle DONE is entered). Both ports may read the same address.
- Latency with no key stalls: iStart high to oDone high = 1 + T + B + 6*max(T,C) cycles. Defaults: 1+26+16+156 = 199.
- iKey_valid outside LOAD_KEY is ignored. The byte count never exceeds B.

Optional Feature:
RC5_KEY_ZEROIZE_EN
- Defined: when iStart falls from any non-IDLE state, the block enters WIPE, writing 0 to S[k] and to L[k] (for k<C) at one index per cycle for max(T,C) cycles, then goes to IDLE. iStart is ignored during WIPE; reset during WIPE still forces IDLE.
- Undefined: no WIPE state; arrays keep stale contents (reads are still gated to 0 by oDone=0).

Test Plan:
- Key all zero (W=32,R=12,B=16), then run the decipher on A=0xEEDBA521, B=0x6D8F4B15 using this block's S → A=B=0x00000000. oDone rises exactly 199 cycles after iStart.
- Key 91 5F 46 19 BE 41 B2 51 63 55 A5 01 10 A9 CE 91 (K[0] first as listed, so presented last); ciphertext words A=0xAC13C0F7, B=0x52892B5B → A=0xEEDBA521, B=0x6D8F4B15.
- Key bytes with iKey_valid toggling 1-0-0-1 → identical S to the unstalled run; oDone is delayed by exactly the number of idle cycles.
- iStart dropped mid-MIX, then raised again with the same key → oDone=0 within 1 cycle; the rerun table matches the clean run.
- Before oDone, read any address → 0. After oDone, read iS_address1=iS_address2=5 → both ports equal after 1 cycle.
- rst asserted low mid-LOAD_KEY, asynchronous to clk → outputs 0 immediately, state IDLE. With RC5_KEY_ZEROIZE_EN defined, an abort is followed by max(T,C)=26 wipe cycles and all S words read 0 via backdoor.
